seq_det_scheduler: RTL and testbench

//  Round-robin controller sharing one serial Mealy sequence detector among N_REQ requesters.

---
 rtl/seq_sched_pkg.sv | 17 +
 rtl/seq_det_scheduler_rr_arbiter.sv | 30 +++
 rtl/seq_det_scheduler.sv | 124 ++++++++++++
 tb/tb_seq_det_scheduler.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_sched_pkg.sv
// Shared constants for the round-robin sequence-detector scheduler.
// State encoding and parameter width helpers.
package seq_sched_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CLEAR  = 2'd1;
  localparam logic [1:0] ST_SHIFT  = 2'd2;
  localparam logic [1:0] ST_REPORT = 2'd3;

  localparam int DEF_N_REQ     = 4;
  localparam int DEF_FRAME_LEN = 8;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_det_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr wins,
// searching upward and wrapping from N_REQ-1 back to 0.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(ptr) + k) % N_REQ;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/seq_det_scheduler.sv
// Shares one serial Mealy detector among N_REQ frame producers, round-robin.
// Define SEQ_SCHED_EARLY_EXIT_EN to stop at the first hit and report its bit position.
module seq_det_scheduler
  import seq_sched_pkg::*;
#(
  parameter int N_REQ     = DEF_N_REQ,
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int ID_W      = id_width(N_REQ),
  parameter int CNT_W     = id_width(FRAME_LEN + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*FRAME_LEN-1:0] req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       det_clr,
  output logic                       det_d_in,
  output logic                       det_en,
  input  logic                       det_hit,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [ID_W-1:0]            res_id,
  output logic [CNT_W-1:0]           res_count,
  output logic                       busy
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_REQ - 1);

  logic [1:0]           state_q, state_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     bitcnt_q, bitcnt_d;
  logic [FRAME_LEN-1:0] sreg_q, sreg_d;

  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_idx;
  logic             gnt_any;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    cnt_d    = cnt_q;
    bitcnt_d = bitcnt_q;
    sreg_d   = sreg_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          sreg_d   = req_data[int'(gnt_idx)*FRAME_LEN +: FRAME_LEN];
          id_d     = gnt_idx;
          cnt_d    = '0;
          bitcnt_d = '0;
          state_d  = ST_CLEAR;
        end
      end
      ST_CLEAR: state_d = ST_SHIFT;
      ST_SHIFT: begin
        sreg_d   = sreg_q << 1;
        bitcnt_d = bitcnt_q + CNT_W'(1);
`ifdef SEQ_SCHED_EARLY_EXIT_EN
        // count holds the 1-based position of the first hit
        if (det_hit) begin
          cnt_d   = bitcnt_q + CNT_W'(1);
          state_d = ST_REPORT;
        end else if (bitcnt_q == LAST_BIT) begin
          state_d = ST_REPORT;
        end
`else
        if (det_hit) cnt_d = cnt_q + CNT_W'(1);
        if (bitcnt_q == LAST_BIT) state_d = ST_REPORT;
`endif
      end
      ST_REPORT: begin
        if (res_ready) begin
          rr_ptr_d = (id_q == LAST_ID) ? '0 : id_q + ID_W'(1);
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      cnt_q    <= '0;
      bitcnt_q <= '0;
      sreg_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      cnt_q    <= cnt_d;
      bitcnt_q <= bitcnt_d;
      sreg_q   <= sreg_d;
    end
  end

  // ready is combinational, so mask it while reset is held
  assign req_ready = (state_q == ST_IDLE && !reset) ? gnt : '0;
  assign det_clr   = (state_q == ST_CLEAR);
  assign det_en    = (state_q == ST_SHIFT);
  assign det_d_in  = det_en & sreg_q[FRAME_LEN-1];
  assign res_valid = (state_q == ST_REPORT);
  assign res_id    = id_q;
  assign res_count = cnt_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Bench for seq_det_scheduler with an overlapping Mealy "1011" detector model.
// Vector table plus scoreboard; expectations follow SEQ_SCHED_EARLY_EXIT_EN.
module tb_seq_det_scheduler;

  localparam int N_REQ     = 4;
  localparam int FRAME_LEN = 8;
  localparam int ID_W      = 2;
  localparam int CNT_W     = 4;
`ifdef SEQ_SCHED_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic                       clk = 1'b0;
  logic                       reset;
  logic [N_REQ-1:0]           req_valid;
  logic [N_REQ*FRAME_LEN-1:0] req_data;
  logic [N_REQ-1:0]           req_ready;
  logic                       det_clr;
  logic                       det_d_in;
  logic                       det_en;
  logic                       det_hit;
  logic                       res_valid;
  logic                       res_ready;
  logic [ID_W-1:0]            res_id;
  logic [CNT_W-1:0]           res_count;
  logic                       busy;

  always #5 clk = ~clk;

  seq_det_scheduler #(
    .N_REQ     (N_REQ),
    .FRAME_LEN (FRAME_LEN),
    .ID_W      (ID_W),
    .CNT_W     (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .det_clr   (det_clr),
    .det_d_in  (det_d_in),
    .det_en    (det_en),
    .det_hit   (det_hit),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_count (res_count),
    .busy      (busy)
  );

  // detector: three bits of history, hit when history+current == 1011
  logic [2:0] hist;
  always @(posedge clk or posedge reset) begin
    if (reset) hist <= 3'b0;
    else if (det_clr) hist <= 3'b0;
    else if (det_en) hist <= {hist[1:0], det_d_in};
  end
  assign det_hit = det_en && ({hist, det_d_in} == 4'b1011);

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [CNT_W-1:0] cnt;
  } res_t;

  typedef struct {
    int         id;
    logic [7:0] frame;
    int         cnt_full;
    int         cnt_early;
  } vec_t;

  res_t exp_q[$];
  res_t r;
  int   grant_log[$];
  int   checks = 0;
  int   errors = 0;
  logic prev_clr = 1'b0;
  logic prev_en  = 1'b0;
  logic prev_rdy = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (|req_ready) begin
        checks++;
        if (!$onehot(req_ready) || prev_rdy) begin
          errors++;
          $display("FAIL ready_pulse got %b prev=%0b want one-hot 1-cycle",
                   req_ready, prev_rdy);
        end
        for (int i = 0; i < N_REQ; i++)
          if (req_ready[i]) grant_log.push_back(i);
      end
      if (prev_clr) begin
        checks++;
        if (!det_en || det_clr) begin
          errors++;
          $display("FAIL clr_then_en got clr=%0b en=%0b want clr=0 en=1",
                   det_clr, det_en);
        end
      end
      if (det_en && !prev_en && !prev_clr) begin
        checks++;
        errors++;
        $display("FAIL en_without_clr got prev_clr=0 want 1");
      end
      if (res_valid && res_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL res_unexpected got id=%0d cnt=%0d want none",
                   res_id, res_count);
        end else begin
          r = exp_q.pop_front();
          if (res_id !== r.id || res_count !== r.cnt) begin
            errors++;
            $display("FAIL result got id=%0d cnt=%0d want id=%0d cnt=%0d",
                     res_id, res_count, r.id, r.cnt);
          end
        end
      end
    end
    prev_clr = det_clr && !reset;
    prev_en  = det_en && !reset;
    prev_rdy = (|req_ready) && !reset;
  end

  function automatic int exp_cnt(input vec_t v);
    return EARLY ? v.cnt_early : v.cnt_full;
  endfunction

  task automatic drive_req(input int id, input logic [7:0] f,
                           input int cnt, input bit push);
    req_data[id*FRAME_LEN +: FRAME_LEN] = f;
    req_valid[id] = 1'b1;
    if (push) exp_q.push_back('{id: ID_W'(id), cnt: CNT_W'(cnt)});
  endtask

  task automatic wait_grant(input int id);
    int n;
    n = 0;
    while (n < 60) begin
      @(negedge clk);
      if (req_ready[id]) break;
      n++;
    end
    checks++;
    if (n >= 60) begin
      errors++;
      $display("FAIL grant_timeout got no req_ready[%0d] want pulse", id);
    end
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_res(output int lat);
    lat = 0;
    while (lat < 60) begin
      @(negedge clk);
      lat++;
      if (res_valid) break;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    int   lat, exp_lat, s, c;
    int   ord[5];
    bit   ok;

    tbl[0] = '{0, 8'b1011_1011, 2, 4};
    tbl[1] = '{1, 8'h00,        0, 0};
    tbl[2] = '{2, 8'b1011_0110, 2, 4};
    tbl[3] = '{0, 8'b0101_1000, 1, 5};
    tbl[4] = '{1, 8'b1101_1011, 2, 5};
    tbl[5] = '{2, 8'hFF,        0, 0};
    tbl[6] = '{0, 8'b0010_1101, 1, 6};
    tbl[7] = '{3, 8'b1011_1111, 1, 4};
    ord = '{0, 1, 2, 3, 0};

    reset = 1'b1;
    req_valid = '0;
    req_data = '0;
    res_ready = 1'b1;
    req_valid[2] = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy || req_ready != 0 || res_valid || det_clr || det_en ||
        det_d_in || res_id != 0 || res_count != 0) begin
      errors++;
      $display("FAIL reset_out got busy=%0b rdy=%b rv=%0b want all 0",
               busy, req_ready, res_valid);
    end
    req_valid = '0;
    reset = 1'b0;

    // table: one requester per frame, latency and result per entry
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      c = exp_cnt(tbl[i]);
      drive_req(tbl[i].id, tbl[i].frame, c, 1'b1);
      wait_grant(tbl[i].id);
      wait_res(lat);
      exp_lat = (EARLY && c != 0) ? 2 + c : FRAME_LEN + 2;
      checks++;
      if (lat != exp_lat) begin
        errors++;
        $display("FAIL latency[%0d] got %0d want %0d", i, lat, exp_lat);
      end
      @(posedge clk); #1;
    end
    wait_drain();

    // all four requesters hold valid: grants must rotate 0,1,2,3,0
    @(posedge clk); #1;
    s = grant_log.size();
    drive_req(0, tbl[0].frame, exp_cnt(tbl[0]), 1'b1);
    drive_req(1, tbl[1].frame, exp_cnt(tbl[1]), 1'b1);
    drive_req(2, tbl[2].frame, exp_cnt(tbl[2]), 1'b1);
    drive_req(3, tbl[6].frame, exp_cnt(tbl[6]), 1'b1);
    exp_q.push_back('{id: 2'd0, cnt: CNT_W'(exp_cnt(tbl[0]))});
    c = 0;
    while (grant_log.size() < s + 5 && c < 200) begin
      @(negedge clk); #1;
      c++;
    end
    @(posedge clk); #1;
    req_valid = '0;
    wait_drain();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (grant_log.size() <= s + k || grant_log[s+k] != ord[k]) begin
        errors++;
        $display("FAIL rr_order[%0d] got %0d want %0d", k,
                 (grant_log.size() > s + k) ? grant_log[s+k] : -1, ord[k]);
      end
    end

    // back-pressure: result held for 20 cycles, req0 waits its turn
    @(posedge clk); #1;
    res_ready = 1'b0;
    drive_req(2, tbl[0].frame, exp_cnt(tbl[0]), 1'b1);
    wait_grant(2);
    drive_req(0, 8'h00, 0, 1'b1);
    wait_res(lat);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++;
      if (!res_valid || res_id != 2'd2 ||
          res_count != CNT_W'(exp_cnt(tbl[0])) ||
          req_ready != 0 || det_en) begin
        errors++;
        $display("FAIL hold[%0d] got rv=%0b id=%0d cnt=%0d rdy=%b want 1,2,%0d,0",
                 k, res_valid, res_id, res_count, req_ready, exp_cnt(tbl[0]));
      end
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    wait_grant(0);
    wait_drain();

    // abort mid-frame with reset while shifting bit index 4
    @(posedge clk); #1;
    drive_req(1, 8'h00, 0, 1'b0);
    wait_grant(1);
    repeat (6) @(negedge clk);
    checks++;
    if (!det_en || !busy) begin
      errors++;
      $display("FAIL pre_abort got en=%0b busy=%0b want 1,1", det_en, busy);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (busy || det_en || det_clr || det_d_in || res_valid ||
        res_id != 0 || res_count != 0 || req_ready != 0) begin
      errors++;
      $display("FAIL abort_out got busy=%0b en=%0b id=%0d want all 0",
               busy, det_en, res_id);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    ok = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (res_valid || busy) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL post_abort got activity want idle");
    end

    // pointer restarted at 0: req0 beats req3
    @(posedge clk); #1;
    drive_req(0, tbl[6].frame, exp_cnt(tbl[6]), 1'b1);
    drive_req(3, tbl[2].frame, exp_cnt(tbl[2]), 1'b1);
    wait_grant(0);
    wait_grant(3);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
